// File: rtl/vga_line_feeder_pkg.sv
// Shared types for the VGA scanline path: pixel colour, line geometry and
// the line feeder state encoding.
package Types;

    typedef logic [11:0] Color;

    localparam int H_PIXELS_C = 640;
    localparam int V_LINES_C  = 480;

    typedef enum logic [2:0] {
        UNSYNC,
        WAIT,
        REQ,
        FILL,
        FULL
    } feeder_state_t;

endpackage

// File: rtl/vga_line_feeder_edge_det.sv
// Registered falling-edge detector: flags a cycle where the input is low
// but was high on the previous clock.
module edge_det (
    input  logic CLK25MHZ,
    input  logic ck_rst_,
    input  logic d,
    output logic fall
);

    logic d_q;

    // Cleared in reset so a low input at release never looks like an edge.
    always_ff @(posedge CLK25MHZ) begin
        if (!ck_rst_) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign fall = d_q & ~d;

endmodule

// File: rtl/vga_line_feeder.sv
// Double-buffered scanline feeder: requests each upcoming row from a pixel
// source, fills the back bank, and swaps it to the front in h back porch.
module vga_line_feeder
    import Types::*;
#(
    parameter int H_PIXELS  = H_PIXELS_C,
    parameter int V_LINES   = V_LINES_C,
    parameter int FILL_LEAD = 33
) (
    input  logic                       CLK25MHZ,
    input  logic                       ck_rst_,
    input  logic                       next_line,
    input  logic                       vga_vs,
    output logic                       req_valid,
    output logic [9:0]                 req_y,
    input  logic                       pix_valid,
    input  Types::Color                pix_data,
    output logic                       pix_ready,
    output Types::Color [H_PIXELS-1:0] color_out,
    output logic                       underrun
);

    localparam int         XW     = $clog2(H_PIXELS);
    localparam logic [XW-1:0] XLAST = XW'(H_PIXELS - 1);
    localparam logic [9:0] LEAD_L = 10'(FILL_LEAD);
    localparam logic [9:0] LAST_L = 10'(FILL_LEAD + V_LINES - 1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    feeder_state_t state, state_nxt;
    logic [XW-1:0] wr_x, wr_x_nxt;
    logic [9:0]    line_cnt, line_cnt_nxt;
    logic [9:0]    req_y_nxt;
    logic          underrun_nxt;
    logic          swap_ev, sync_ev, due, front_load, beat;

    Types::Color [H_PIXELS-1:0] front;
    Types::Color [H_PIXELS-1:0] back;

    edge_det u_swap_det (
        .CLK25MHZ (CLK25MHZ),
        .ck_rst_  (ck_rst_),
        .d        (next_line),
        .fall     (swap_ev)
    );

    edge_det u_sync_det (
        .CLK25MHZ (CLK25MHZ),
        .ck_rst_  (ck_rst_),
        .d        (vga_vs),
        .fall     (sync_ev)
    );

    always_comb begin
        state_nxt    = state;
        wr_x_nxt     = wr_x;
        line_cnt_nxt = line_cnt;
        req_y_nxt    = req_y;
        underrun_nxt = underrun;
        front_load   = 1'b0;
        beat         = (state == FILL) && pix_valid;
        due          = (line_cnt >= LEAD_L) && (line_cnt <= LAST_L);

        if (swap_ev && (line_cnt != CNT_MAX)) begin
            line_cnt_nxt = line_cnt + 10'd1;
        end

        // Sync outranks a coincident swap; the front bank is left alone.
        if (sync_ev) begin
            state_nxt    = WAIT;
            line_cnt_nxt = '0;
        end else if (swap_ev && (state != UNSYNC)) begin
            if (state == FULL) begin
                front_load = 1'b1;
            end
            if ((state == FILL) || (state == REQ)) begin
                underrun_nxt = 1'b1;
            end
            if (due) begin
                state_nxt = REQ;
                req_y_nxt = line_cnt - LEAD_L;
            end else begin
                state_nxt = WAIT;
            end
        end else begin
            case (state)
                REQ: begin
                    state_nxt = FILL;
                    wr_x_nxt  = '0;
                end
                FILL: begin
                    if (pix_valid) begin
                        if (wr_x == XLAST) begin
                            state_nxt = FULL;
                        end else begin
                            wr_x_nxt = wr_x + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK25MHZ) begin
        if (!ck_rst_) begin
            state    <= UNSYNC;
            wr_x     <= '0;
            line_cnt <= '0;
            req_y    <= '0;
            underrun <= 1'b0;
            front    <= '0;
        end else begin
            state    <= state_nxt;
            wr_x     <= wr_x_nxt;
            line_cnt <= line_cnt_nxt;
            req_y    <= req_y_nxt;
            underrun <= underrun_nxt;
            if (front_load) begin
                front <= back;
            end
        end
    end

    always_ff @(posedge CLK25MHZ) begin
        if (beat) begin
            back[wr_x] <= pix_data;
        end
    end

    assign req_valid = (state == REQ);
    assign pix_ready = (state == FILL);
    assign color_out = front;

endmodule

// File: tb/tb_vga_line_feeder.sv
// Bench for vga_line_feeder: drives scanline/vsync timing, plays a pixel
// source that answers each request, and scoreboards requests and banks.
module tb_vga_line_feeder;
    import Types::*;

    localparam int H = 640;

    logic           clk;
    logic           ck_rst_;
    logic           next_line;
    logic           vga_vs;
    logic           req_valid;
    logic [9:0]     req_y;
    logic           pix_valid;
    Color           pix_data;
    logic           pix_ready;
    Color [H-1:0]   color_out;
    logic           underrun;

    vga_line_feeder dut (
        .CLK25MHZ  (clk),
        .ck_rst_   (ck_rst_),
        .next_line (next_line),
        .vga_vs    (vga_vs),
        .req_valid (req_valid),
        .req_y     (req_y),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .color_out (color_out),
        .underrun  (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int m_cnt = 0;
    bit synced = 1'b0;
    bit got_req = 1'b0;
    int last_y = -1;
    int n_req = 0;
    int src_x = 0;
    int src_row = 0;
    bit src_stall = 1'b0;
    bit tog = 1'b0;

    typedef struct {
        int cnt;
        bit req;
        int y;
    } vec_t;
    vec_t vec[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic Color pat(input int row, input int x);
        return 12'(row * 13 + x);
    endfunction

    task automatic check_front(input int row, input string name);
        int bad;
        bad = 0;
        for (int x = 0; x < H; x++) begin
            if (color_out[x] !== pat(row, x)) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Pixel source and request scoreboard, both acting on the falling edge.
    initial begin
        int ey;
        pix_valid = 1'b0;
        pix_data  = '0;
        forever begin
            @(negedge clk);
            if (req_valid) begin
                got_req = 1'b1;
                last_y  = int'(req_y);
                n_req++;
                src_x   = 0;
                src_row = int'(req_y);
                chk("sb_req_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ey = exp_q.pop_front();
                    chk("sb_req_y", int'(req_y), ey);
                end
            end
            tog = ~tog;
            pix_valid = !src_stall || tog;
            pix_data  = pat(src_row, src_x);
            if (pix_valid && pix_ready) src_x++;
        end
    end

    task automatic line_hi(input int n);
        repeat (n) begin
            @(negedge clk);
            next_line = 1'b1;
        end
    endtask

    task automatic line_fall();
        got_req = 1'b0;
        @(negedge clk);
        next_line = 1'b0;
        if (synced && m_cnt >= 33 && m_cnt <= 512) exp_q.push_back(m_cnt - 33);
        if (m_cnt < 1023) m_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task automatic sync_pulse();
        @(negedge clk);
        vga_vs = 1'b0;
        m_cnt  = 0;
        synced = 1'b1;
        @(negedge clk);
        vga_vs = 1'b1;
    endtask

    task automatic wait_src(input int n);
        for (int i = 0; i < 3000 && src_x < n; i++) @(negedge clk);
        chk("wait_src_reached", int'(src_x >= n), 1);
    endtask

    initial begin
        vec[0] = '{32, 1'b0, 0};
        vec[1] = '{33, 1'b1, 0};
        vec[2] = '{34, 1'b1, 1};
        vec[3] = '{35, 1'b1, 2};
        vec[4] = '{36, 1'b1, 3};
        vec[5] = '{511, 1'b1, 478};
        vec[6] = '{512, 1'b1, 479};
        vec[7] = '{513, 1'b0, 0};
        vec[8] = '{514, 1'b0, 0};
        vec[9] = '{524, 1'b0, 0};

        ck_rst_   = 1'b0;
        next_line = 1'b0;
        vga_vs    = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_req_valid", int'(req_valid), 0);
        chk("rst_req_y", int'(req_y), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_color_out_zero", int'(color_out == '0), 1);
        ck_rst_ = 1'b1;

        // Unsynchronised: swaps past the lead line still issue nothing.
        for (int i = 0; i < 40; i++) begin
            line_hi(4);
            line_fall();
        end
        chk("unsync_no_req", n_req, 0);

        // Full frame sweep; long lines where a row must complete.
        sync_pulse();
        for (int c = 0; c <= 524; c++) begin
            src_stall = (c == 35);
            line_hi((c == 34 || c == 35 || c == 513) ? 660 : 4);
            line_fall();
            src_stall = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (vec[k].cnt == c) begin
                    chk("tbl_req_seen", int'(got_req), int'(vec[k].req));
                    if (vec[k].req) chk("tbl_req_y", last_y, vec[k].y);
                end
            end
            if (c == 34) begin
                check_front(0, "row0_front");
                chk("underrun_clean", int'(underrun), 0);
            end
            if (c == 35) begin
                check_front(0, "stall_front_kept");
                chk("underrun_set", int'(underrun), 1);
            end
            if (c == 513) check_front(479, "row479_front");
        end

        // Next frame restarts at row 0.
        sync_pulse();
        for (int c = 0; c <= 33; c++) begin
            line_hi(4);
            line_fall();
            if (c == 32) chk("restart_no_early_req", int'(got_req), 0);
        end
        chk("restart_req_seen", int'(got_req), 1);
        chk("restart_req_y", last_y, 0);

        // Resync in the middle of a fill.
        next_line = 1'b1;
        wait_src(300);
        sync_pulse();
        chk("resync_pix_ready", int'(pix_ready), 0);
        check_front(479, "resync_front_kept");
        line_fall();
        for (int c = 1; c <= 33; c++) begin
            line_hi(4);
            line_fall();
        end
        chk("resync_req_seen", int'(got_req), 1);
        chk("resync_req_y", last_y, 0);

        // Reset in the middle of a fill.
        next_line = 1'b1;
        wait_src(100);
        chk("fill_active", int'(pix_ready), 1);
        @(negedge clk);
        ck_rst_ = 1'b0;
        @(negedge clk);
        chk("midrst_req_valid", int'(req_valid), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        chk("midrst_underrun", int'(underrun), 0);
        chk("midrst_req_y", int'(req_y), 0);
        chk("midrst_color_zero", int'(color_out == '0), 1);
        ck_rst_ = 1'b1;
        synced  = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
        n_req = 0;
        line_fall();
        for (int i = 0; i < 40; i++) begin
            line_hi(4);
            line_fall();
        end
        chk("postrst_no_req", n_req, 0);
        sync_pulse();
        for (int c = 0; c <= 33; c++) begin
            line_hi(4);
            line_fall();
        end
        chk("postrst_req_seen", int'(got_req), 1);
        chk("postrst_req_y", last_y, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
